// File: rtl/hamming_serial_encoder_if.sv
// hamming_serial_encoder_if: serial bit input and codeword output handshake bundle
interface hamming_serial_encoder_if #(parameter int CODE_W = 7);
  logic              write;
  logic              data_inp;
  logic              abort;
  logic              ready;
  logic [CODE_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;
  modport master (output write, data_inp, abort, out_ready, input ready, data_out, out_valid, overrun);
  modport slave (input write, data_inp, abort, out_ready, output ready, data_out, out_valid, overrun);
endinterface

// File: rtl/hamming_serial_encoder.sv
// hamming_serial_encoder: collects DATA_W serial bits and emits a Hamming (optionally SEC-DED) codeword
module hamming_serial_encoder #(
  parameter int DATA_W = 4,
  parameter bit SECDED = 1'b0
) (
  input logic clk,
  input logic reset,
  hamming_serial_encoder_if.slave bus
);
  function automatic int calc_par_w(input int d);
    int r;
    r = 1;
    while ((1 << r) < d + r + 1) r++;
    return r;
  endfunction
  localparam int PAR_W = calc_par_w(DATA_W);
  localparam int N = DATA_W + PAR_W;
  localparam int CODE_W = N + int'(SECDED);
  localparam int CNT_W = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {COLLECT, ENCODE, HOLD} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, sel;
  logic [CODE_W-1:0] data_out_q, data_out_d, code;
  logic [N-1:0] ham;
  logic out_valid_q, out_valid_d, overrun_q, overrun_d, last_bit;
  assign last_bit = cnt_q == CNT_W'(DATA_W - 1);
  assign sel = DATA_W'(1) << cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: state_d = (bus.write && !bus.abort && last_bit) ? ENCODE : COLLECT;
      ENCODE:  state_d = HOLD;
      HOLD:    state_d = bus.out_ready ? COLLECT : HOLD;
      default: state_d = COLLECT;
    endcase
  end
  // abort wins over a simultaneous write; bit k of the word lands in shift_q[k]
  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    overrun_d   = bus.write && state_q != COLLECT;
    if (state_q == COLLECT && bus.abort) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (state_q == COLLECT && bus.write) begin
      shift_d = (shift_q & ~sel) | (bus.data_inp ? sel : '0);
      cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
    end
    if (state_q == ENCODE) begin
      data_out_d  = code;
      out_valid_d = 1'b1;
    end
    if (state_q == HOLD && bus.out_ready) out_valid_d = 1'b0;
  end
  always_comb begin
    logic [DATA_W-1:0] rem;
    ham = '0;
    rem = shift_q;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        ham[p-1] = rem[0];
        rem = rem >> 1;
      end
    for (int j = 0; j < PAR_W; j++)
      for (int p = 1; p <= N; p++)
        if (((p >> j) & 1) != 0 && (p & (p - 1)) != 0) ham[(1 << j) - 1] = ham[(1 << j) - 1] ^ ham[p-1];
    code = CODE_W'({^ham, ham});
  end
  assign bus.ready     = state_q == COLLECT;
  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_hamming_serial_encoder.sv
// tb_hamming_serial_encoder: scoreboard bench for SEC (4-bit), SEC-DED (4-bit) and 11-bit encoders
module tb_hamming_serial_encoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic [2:0] wr = '0, din = '0, ab = '0, ordy = '0;
  logic [2:0] rdy, vld, ovr;
  hamming_serial_encoder_if #(.CODE_W(7))  b0();
  hamming_serial_encoder_if #(.CODE_W(8))  b1();
  hamming_serial_encoder_if #(.CODE_W(15)) b2();
  hamming_serial_encoder #(.DATA_W(4),  .SECDED(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  hamming_serial_encoder #(.DATA_W(4),  .SECDED(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  hamming_serial_encoder #(.DATA_W(11), .SECDED(1'b0)) u2 (.clk(clk), .reset(reset), .bus(b2));
  assign {b2.write, b1.write, b0.write} = wr;
  assign {b2.data_inp, b1.data_inp, b0.data_inp} = din;
  assign {b2.abort, b1.abort, b0.abort} = ab;
  assign {b2.out_ready, b1.out_ready, b0.out_ready} = ordy;
  assign rdy = {b2.ready, b1.ready, b0.ready};
  assign vld = {b2.out_valid, b1.out_valid, b0.out_valid};
  assign ovr = {b2.overrun, b1.overrun, b0.overrun};
  logic [71:0] q0[$], q1[$], q2[$];
  int rise0[$];
  logic pv0 = 1'b0;
  logic [7:0] last1 = '0;
  function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction
  function automatic void unexpected(input int inst, input logic [71:0] act);
    compared++;
    mismatched++;
    $display("FAIL unexpected_word inst %0d: got %h, required none", inst, act);
  endfunction
  function automatic logic [71:0] ref_enc(input logic [63:0] d, input int dw, input int pw, input bit sec);
    logic [71:0] c;
    int syn, k, pos;
    c = '0; syn = 0; k = 0; pos = 0;
    while (k < dw) begin
      pos++;
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        if (d[k]) syn ^= pos;
        k++;
      end
    end
    for (int j = 0; j < pw; j++) c[(1 << j) - 1] = syn[j];
    if (sec) c[dw+pw] = ^c;
    return c;
  endfunction
  function automatic int syn7(input logic [7:0] w);
    int s;
    s = 0;
    for (int p = 1; p <= 7; p++) if (w[p-1]) s ^= p;
    return s;
  endfunction
  always @(negedge clk) if (reset && vld[0] && ordy[0]) begin
    if (q0.size() == 0) unexpected(0, 72'(b0.data_out));
    else chk("word0", 72'(b0.data_out), q0.pop_front());
  end
  always @(negedge clk) if (reset && vld[1] && ordy[1]) begin
    last1 = b1.data_out;
    if (q1.size() == 0) unexpected(1, 72'(b1.data_out));
    else chk("word1", 72'(b1.data_out), q1.pop_front());
  end
  always @(negedge clk) if (reset && vld[2] && ordy[2]) begin
    if (q2.size() == 0) unexpected(2, 72'(b2.data_out));
    else chk("word2", 72'(b2.data_out), q2.pop_front());
  end
  always @(negedge clk) begin
    if (vld[0] && !pv0) rise0.push_back(cyc);
    pv0 = vld[0];
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send_bit(input int inst, input logic b);
    int n = 0;
    while (!rdy[inst] && n < 100) begin tick(1); n++; end
    if (n >= 100) begin
      compared++; mismatched++;
      $display("FAIL send_timeout inst %0d: ready 0, required 1", inst);
    end
    wr[inst] = 1'b1; din[inst] = b;
    tick(1);
    wr[inst] = 1'b0;
  endtask
  task automatic send_word(input int inst, input logic [63:0] d, input int n, input logic [71:0] exp);
    if (inst == 0) q0.push_back(exp);
    else if (inst == 1) q1.push_back(exp);
    else q2.push_back(exp);
    for (int i = 0; i < n; i++) send_bit(inst, d[i]);
  endtask
  task automatic wait_valid(input int inst);
    int n = 0;
    while (!vld[inst] && n < 50) begin tick(1); n++; end
    if (n >= 50) begin
      compared++; mismatched++;
      $display("FAIL valid_timeout inst %0d: out_valid 0, required 1", inst);
    end
  endtask
  task automatic check_reset_outputs(input string tag, input int inst);
    chk({tag, "_ready"}, 72'(rdy[inst]), 72'd1);
    chk({tag, "_out_valid"}, 72'(vld[inst]), 72'd0);
    chk({tag, "_overrun"}, 72'(ovr[inst]), 72'd0);
    chk({tag, "_data_out"}, inst == 0 ? 72'(b0.data_out) : inst == 1 ? 72'(b1.data_out) : 72'(b2.data_out), 72'd0);
  endtask
  initial begin
    logic [63:0] d;
    #12;
    check_reset_outputs("rst0", 0);
    @(posedge clk); #1;
    reset = 1'b1;
    // single word, held: bits 1,0,1,0
    send_word(0, 64'b0101, 4, 72'b0101101);
    chk("encode_cycle_valid", 72'(vld[0]), 72'd0);
    chk("encode_cycle_ready", 72'(rdy[0]), 72'd0);
    tick(1);
    chk("latency_valid", 72'(vld[0]), 72'd1);
    chk("latency_data", 72'(b0.data_out), 72'b0101101);
    ordy[0] = 1'b1;
    tick(1);
    chk("consume_valid", 72'(vld[0]), 72'd0);
    chk("consume_ready", 72'(rdy[0]), 72'd1);
    // back-to-back throughput
    rise0.delete();
    send_word(0, 64'b0101, 4, 72'b0101101);
    send_word(0, 64'b1001, 4, 72'b1001100);
    send_word(0, 64'b0110, 4, 72'b0110011);
    tick(4);
    chk("b2b_words", 72'(rise0.size()), 72'd3);
    if (rise0.size() == 3) begin
      chk("b2b_period1", 72'(rise0[1] - rise0[0]), 72'd6);
      chk("b2b_period2", 72'(rise0[2] - rise0[1]), 72'd6);
    end
    // SEC-DED word and single-bit-flip decoding of the emitted codeword
    ordy[1] = 1'b1;
    send_word(1, 64'b0101, 4, 72'b00101101);
    tick(4);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = last1 ^ (8'd1 << i);
      chk($sformatf("flip%0d_syndrome", i), 72'(syn7(w)), i < 7 ? 72'(i + 1) : 72'd0);
      chk($sformatf("flip%0d_overall", i), 72'(^w), 72'd1);
    end
    // overrun while held
    ordy[0] = 1'b0;
    send_word(0, 64'b0101, 4, 72'b0101101);
    wait_valid(0);
    for (int i = 0; i < 10; i++) begin
      wr[0] = 1'b1; din[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i > 0) chk("hold_overrun", 72'(ovr[0]), 72'd1);
      chk("hold_ready", 72'(rdy[0]), 72'd0);
      chk("hold_data", 72'(b0.data_out), 72'b0101101);
      @(posedge clk); #1;
    end
    wr[0] = 1'b0;
    @(negedge clk);
    chk("overrun_last", 72'(ovr[0]), 72'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("overrun_clear", 72'(ovr[0]), 72'd0);
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    send_word(0, 64'b1001, 4, 72'b1001100);
    tick(4);
    // abort with simultaneous write after two bits
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    ab[0] = 1'b1; wr[0] = 1'b1; din[0] = 1'b1;
    tick(1);
    ab[0] = 1'b0; wr[0] = 1'b0;
    @(negedge clk);
    chk("abort_overrun", 72'(ovr[0]), 72'd0);
    chk("abort_ready", 72'(rdy[0]), 72'd1);
    @(posedge clk); #1;
    send_word(0, 64'b0101, 4, 72'b0101101);
    tick(4);
    // DATA_W=11 against the reference model
    ordy[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 64'($urandom_range(0, 2047));
      send_word(2, d, 11, ref_enc(d, 11, 4, 1'b0));
    end
    tick(4);
    for (int i = 0; i < 5; i++) send_bit(2, 1'($urandom_range(0, 1)));
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_midword", 2);
    tick(1);
    reset = 1'b1;
    ordy[2] = 1'b0;
    d = 64'h5A3;
    send_word(2, d, 11, ref_enc(d, 11, 4, 1'b0));
    wait_valid(2);
    reset = 1'b0;
    #1;
    q2.delete();
    check_reset_outputs("rst_midhold", 2);
    tick(1);
    reset = 1'b1;
    ordy[2] = 1'b1;
    d = 64'h2C7;
    send_word(2, d, 11, ref_enc(d, 11, 4, 1'b0));
    tick(4);
    chk("drain0", 72'(q0.size()), 72'd0);
    chk("drain1", 72'(q1.size()), 72'd0);
    chk("drain2", 72'(q2.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
